tx_scheduler: RTL and testbench
===============================

# tx_scheduler

Schedules USB transmit packets for the TX packet unit. It arbitrates NAK and DATA requests from the RX protocol unit and checks that a full packet is buffered in the TX FIFO before starting DATA. It then pulses the packet unit's `send_nak`/`send_data` inputs, tracks the packet through the `is_txing` handshake, and enforces an inter-packet gap. It sits between the RX protocol unit and the TX packet unit, which it sequences.

## Interface
Parameters:
- `PKT_BYTES`, 64: bytes in one DATA payload; DATA is launched only when `fifo_count >= PKT_BYTES`.
- `CNT_W`, 7: width of `fifo_count`.
- `GAP_CYCLES`, 16: idle cycles enforced after each packet; must be ≥ 1.
- `START_TIMEOUT`, 8: cycles allowed for `is_txing` to rise after launch; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `nak_req`  in  1  RX unit requests a NAK; level, held until `req_ack`.
- `data_req`  in  1  RX unit requests DATA (IN token); level, held until `req_ack`.
- `fifo_count`  in  CNT_W  bytes currently held in the TX FIFO.
- `is_txing`  in  1  TX packet unit is transmitting.
- `send_nak`  out  1  one-cycle pulse to the TX packet unit.
- `send_data`  out  1  one-cycle pulse to the TX packet unit.
- `req_ack`  out  1  one-cycle pulse: the pending request was accepted.
- `pkt_kind`  out  1  kind of the current or last packet: 0 = NAK, 1 = DATA.
- `tx_done`  out  1  one-cycle pulse when a packet finishes.
- `start_err`  out  1  sticky; `is_txing` never rose within `START_TIMEOUT`.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, LAUNCH, WAIT_START, BUSY, GAP. One shared down-counter serves both WAIT_START and GAP.
- IDLE:
  - `nak_req=1` → LAUNCH, latch kind NAK.
  - Else `data_req=1` → LAUNCH. Latch kind DATA if `fifo_count >= PKT_BYTES`; otherwise latch NAK (substituted NAK, USB no-data response).
  - Else stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - `req_ack=1`.
  - `send_nak` or `send_data` = 1 according to the latched kind.
  - Load counter with `START_TIMEOUT-1`, then → WAIT_START.
- WAIT_START:
  - `is_txing=1` → BUSY.
  - Else, counter reaches 0 → set `start_err`, load `GAP_CYCLES-1`, → GAP.
  - Else decrement the counter.
- BUSY:
  - `is_txing=0` → `tx_done` pulse on that transition cycle, load `GAP_CYCLES-1`, → GAP.
- GAP:
  - Decrement the counter; at 0 → IDLE.
  - Requests are not sampled in GAP.
- `start_err` clears on the next `req_ack`.
- `pkt_kind` holds its value until the next acceptance.
- Requests are sampled only in IDLE. Requests asserted in any other state stay pending and are not lost, because requesters hold them.
- When both requests are high, NAK wins. `data_req` stays pending and is serviced after the gap.
- `fifo_count == PKT_BYTES` → DATA; `PKT_BYTES-1` → substituted NAK.

## Timing
- All outputs are registered or Moore-decoded from state; there is no combinational path from inputs to outputs.
- Reset values: state IDLE, counter 0, and every output 0 (`send_nak`, `send_data`, `req_ack`, `pkt_kind`, `tx_done`, `start_err`, `busy`).
- `n_rst` low at any edge, including mid-packet → all of the above at the next edge. No `tx_done` is generated for an aborted packet.
- Request latency: request seen high at edge k → `req_ack` and send pulse high during cycle k+1.
- The TX packet unit raises `is_txing` one cycle after it samples the send pulse. A compliant packet therefore enters BUSY at edge k+3.
- `tx_done` is high for one cycle, in the cycle after `is_txing` is first seen low in BUSY.
- Minimum packet-to-packet spacing, measured from `is_txing` falling to the next send pulse: `GAP_CYCLES+2` cycles.
- Counter width: `$clog2(max(GAP_CYCLES, START_TIMEOUT))`; the counter never wraps below 0.

## Structure
- Package `tx_sched_pkg` holds:
  - the state enum `tx_sched_state_t`;
  - `KIND_NAK = 1'b0` and `KIND_DATA = 1'b1`;
  - the default `PKT_BYTES`.
- Single module, no sub-module: one state register, one counter, one kind register, one error flag.

## Test plan
- `nak_req` pulsed high in IDLE → `req_ack` and `send_nak` high in the next cycle, `pkt_kind=0`. With `is_txing` high for 20 cycles, then low → one `tx_done` pulse, `busy` low exactly 17 cycles later (`GAP_CYCLES=16`).
- `data_req` with `fifo_count=64` → `send_data` pulse, `pkt_kind=1`. Repeat with `fifo_count=63` → `send_nak` pulse, `pkt_kind=0`, `send_data` never asserted.
- `nak_req` and `data_req` raised together with `fifo_count=64` → NAK is sent first. After the gap, DATA is sent with a second `req_ack`.
- After launch, `is_txing` held at 0 → `start_err=1` after 8 WAIT_START cycles, then GAP, then IDLE. The next accepted request clears `start_err`.
- `n_rst` driven low for one edge while in BUSY → all outputs 0 and state IDLE at the next edge, no `tx_done`. A pending `data_req` is re-accepted one cycle after reset releases.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the USB transmit scheduler.
// Imported by tx_scheduler.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_BUSY,
    S_GAP
  } tx_sched_state_t;

  localparam logic KIND_NAK  = 1'b0;
  localparam logic KIND_DATA = 1'b1;

  localparam int DEF_PKT_BYTES = 64;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_scheduler.sv
// Arbitrates NAK/DATA requests and sequences the TX packet unit,
// tracking is_txing and enforcing an inter-packet gap.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int PKT_BYTES     = DEF_PKT_BYTES,
  parameter int CNT_W         = 7,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             nak_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             is_txing,
  output logic             send_nak,
  output logic             send_data,
  output logic             req_ack,
  output logic             pkt_kind,
  output logic             tx_done,
  output logic             start_err,
  output logic             busy
);

  localparam int TW =
    $clog2(max_int(GAP_CYCLES, START_TIMEOUT));

  localparam logic [TW-1:0] GAP_LOAD =
    TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD =
    TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] ONE = TW'(1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(PKT_BYTES);

  tx_sched_state_t state;
  logic [TW-1:0]   cnt;
  logic            full;

  assign full = (fifo_count >= FULL);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      send_nak  <= 1'b0;
      send_data <= 1'b0;
      req_ack   <= 1'b0;
      pkt_kind  <= KIND_NAK;
      tx_done   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      send_nak  <= 1'b0;
      send_data <= 1'b0;
      req_ack   <= 1'b0;
      tx_done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (nak_req || data_req) begin
            state     <= S_LAUNCH;
            req_ack   <= 1'b1;
            start_err <= 1'b0;
            // NAK wins; DATA without a full packet degrades to NAK
            if (!nak_req && full) begin
              pkt_kind  <= KIND_DATA;
              send_data <= 1'b1;
            end else begin
              pkt_kind  <= KIND_NAK;
              send_nak  <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          cnt   <= START_LOAD;
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (is_txing) begin
            state <= S_BUSY;
          end else if (cnt == '0) begin
            start_err <= 1'b1;
            cnt       <= GAP_LOAD;
            state     <= S_GAP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_BUSY: begin
          if (!is_txing) begin
            tx_done <= 1'b1;
            cnt     <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Randomized self-checking bench for tx_scheduler against a
// transaction-level model of request arbitration and packet timing.
module tb_tx_scheduler;

  localparam int PKT   = 64;
  localparam int GAP   = 16;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       nak_req;
  logic       data_req;
  logic [6:0] fifo_count;
  logic       is_txing;
  logic       send_nak;
  logic       send_data;
  logic       req_ack;
  logic       pkt_kind;
  logic       tx_done;
  logic       start_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  bit stray = 1'b0;
  bit err_exp = 1'b0;
  bit kind_exp = 1'b0;

  tx_scheduler #(
    .PKT_BYTES    (PKT),
    .CNT_W        (7),
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .nak_req   (nak_req),
    .data_req  (data_req),
    .fifo_count(fifo_count),
    .is_txing  (is_txing),
    .send_nak  (send_nak),
    .send_data (send_data),
    .req_ack   (req_ack),
    .pkt_kind  (pkt_kind),
    .tx_done   (tx_done),
    .start_err (start_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_kind(
    input bit nak, input bit data, input int fifo
  );
    if (nak) return 1'b0;
    return (fifo >= PKT);
  endfunction

  task automatic launch(
    input bit nak, input bit data, input int fifo
  );
    bit k;
    k = model_kind(nak, data, fifo);
    nak_req = nak;
    data_req = data;
    fifo_count = 7'(fifo);
    step();
    tests++;
    if (req_ack !== 1'b1 || send_nak !== !k ||
        send_data !== k || pkt_kind !== k ||
        busy !== 1'b1 || start_err !== 1'b0 ||
        tx_done !== 1'b0) begin
      fails++;
      $display("FAIL launch nak=%0b data=%0b fifo=%0d: ack=%b sn=%b sd=%b kind=%b busy=%b err=%b done=%b, want ack=1 sn=%b sd=%b kind=%b busy=1 err=0 done=0",
        nak, data, fifo, req_ack, send_nak, send_data,
        pkt_kind, busy, start_err, tx_done, !k, k, k);
    end
    err_exp = 1'b0;
    kind_exp = k;
    if (nak) nak_req = 1'b0;
    else data_req = 1'b0;
  endtask

  task automatic chk_quiet();
    if (send_nak || send_data || req_ack) stray = 1'b1;
  endtask

  task automatic finish_packet(
    input int tx_len, input bit no_start
  );
    int n;
    int done_at;
    int done_cnt;
    step();
    tests++;
    if (req_ack !== 1'b0 || send_nak !== 1'b0 ||
        send_data !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL post_launch: ack=%b sn=%b sd=%b busy=%b, want 0 0 0 1",
        req_ack, send_nak, send_data, busy);
    end
    done_at = -1;
    done_cnt = 0;
    if (!no_start) begin
      is_txing = 1'b1;
      repeat (tx_len) begin
        step();
        chk_quiet();
        if (tx_done !== 1'b0 || busy !== 1'b1) stray = 1'b1;
      end
      is_txing = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        step();
        n++;
        chk_quiet();
        if (tx_done === 1'b1) begin
          done_cnt++;
          if (done_at < 0) done_at = n;
        end
      end
      tests++;
      if (done_cnt != 1 || done_at != 1) begin
        fails++;
        $display("FAIL tx_done_pulse: count=%0d at=%0d, want count=1 at=1",
          done_cnt, done_at);
      end
      tests++;
      if (n != GAP + 1) begin
        fails++;
        $display("FAIL gap_len: busy low after %0d cycles, want %0d",
          n, GAP + 1);
      end
    end else begin
      n = 0;
      while (start_err !== 1'b1 && n < 50) begin
        step();
        n++;
        chk_quiet();
      end
      tests++;
      if (n != TMO || busy !== 1'b1) begin
        fails++;
        $display("FAIL start_timeout: err after %0d busy=%b, want %0d busy=1",
          n, busy, TMO);
      end
      err_exp = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        step();
        n++;
        chk_quiet();
        if (tx_done === 1'b1) done_cnt++;
      end
      tests++;
      if (n != GAP || done_cnt != 0) begin
        fails++;
        $display("FAIL timeout_gap: idle after %0d done=%0d, want %0d done=0",
          n, done_cnt, GAP);
      end
    end
    tests++;
    if (start_err !== err_exp || pkt_kind !== kind_exp ||
        tx_done !== 1'b0) begin
      fails++;
      $display("FAIL idle_state: err=%b kind=%b done=%b, want err=%b kind=%b done=0",
        start_err, pkt_kind, tx_done, err_exp, kind_exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    tests++;
    if ({send_nak, send_data, req_ack, pkt_kind,
         tx_done, start_err, busy} !== 7'b0) begin
      fails++;
      $display("FAIL %s: outputs sn,sd,ack,kind,done,err,busy=%b, want 0000000",
        name, {send_nak, send_data, req_ack, pkt_kind,
               tx_done, start_err, busy});
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    nak_req = 1'b0;
    data_req = 1'b0;
    fifo_count = '0;
    is_txing = 1'b0;
    repeat (2) step();
    chk_all_zero("reset");
    n_rst = 1'b1;
    repeat (3) step();
    chk_all_zero("idle_no_req");
  endtask

  task automatic test_nak();
    launch(1'b1, 1'b0, 0);
    finish_packet(20, 1'b0);
  endtask

  task automatic test_data_boundary();
    launch(1'b0, 1'b1, PKT);
    finish_packet(7, 1'b0);
    launch(1'b0, 1'b1, PKT - 1);
    finish_packet(3, 1'b0);
  endtask

  task automatic test_back_to_back();
    launch(1'b1, 1'b1, PKT);
    finish_packet(5, 1'b0);
    launch(1'b0, 1'b1, PKT);
    finish_packet(4, 1'b0);
  endtask

  task automatic test_timeout();
    launch(1'b0, 1'b1, PKT);
    finish_packet(0, 1'b1);
    launch(1'b1, 1'b0, 0);
    finish_packet(2, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    launch(1'b0, 1'b1, PKT);
    step();
    is_txing = 1'b1;
    repeat (3) step();
    data_req = 1'b1;
    n_rst = 1'b0;
    step();
    chk_all_zero("reset_mid_busy");
    n_rst = 1'b1;
    is_txing = 1'b0;
    launch(1'b0, 1'b1, PKT);
    finish_packet(6, 1'b0);
  endtask

  task automatic test_random();
    bit nak;
    bit data;
    bit ns;
    int fifo;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) begin
        step();
        chk_quiet();
        if (busy !== 1'b0) stray = 1'b1;
      end
      nak = 1'($urandom_range(0, 1));
      data = nak ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 3) == 0)
        fifo = $urandom_range(0, 127);
      else
        fifo = $urandom_range(PKT - 2, PKT + 2);
      ns = ($urandom_range(0, 7) == 0);
      launch(nak, data, fifo);
      finish_packet($urandom_range(1, 25), ns);
      if (nak && data) begin
        launch(1'b0, 1'b1, fifo);
        finish_packet($urandom_range(1, 25), 1'b0);
      end
    end
  endtask

  task automatic test_no_stray();
    tests++;
    if (stray !== 1'b0) begin
      fails++;
      $display("FAIL stray_pulses: unexpected pulse/busy seen=%b, want 0",
        stray);
    end
  endtask

  initial begin
    test_reset();
    test_nak();
    test_data_boundary();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    test_no_stray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
